// File: rtl/wave_gen_pkg.sv
// Shared definitions for the waveform generator: mode encodings, triangle
// direction states, midscale constant and the shape-select function.
package wave_gen_pkg;

    localparam logic [2:0] MODE_SAW  = 3'b000;
    localparam logic [2:0] MODE_RSAW = 3'b001;
    localparam logic [2:0] MODE_TRI  = 3'b010;
    localparam logic [2:0] MODE_SQR  = 3'b011;

    localparam logic [7:0] MIDSCALE = 8'h80;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Any mode with bit 2 set is reserved and parks the output at midscale.
    function automatic logic [7:0] wave_select(input logic [2:0] mode,
                                               input logic [7:0] ph,
                                               input logic [7:0] tri_val);
        logic [7:0] sample;
        case (mode)
            MODE_SAW:  sample = ph;
            MODE_RSAW: sample = ~ph;
            MODE_TRI:  sample = tri_val;
            MODE_SQR:  sample = ph[7] ? 8'hFF : 8'h00;
            default:   sample = MIDSCALE;
        endcase
        return sample;
    endfunction

endpackage

// File: rtl/wave_prescaler.sv
// Sample-rate prescaler: counts enabled cycles and flags a step when the
// count reaches the programmed terminal value.
module wave_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] freq_div,
    output logic             step
);

    logic [DIV_W-1:0] pcnt_reg;

    // >= rather than == so lowering freq_div below the running count
    // fires on the next enabled cycle instead of wrapping the counter.
    assign step = enable && (pcnt_reg >= freq_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_reg <= '0;
        end else if (step) begin
            pcnt_reg <= '0;
        end else if (enable) begin
            pcnt_reg <= pcnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/wave_gen.sv
// Programmable 8-bit waveform source: phase counter, triangle up/down FSM and
// a registered shape mux, all advanced by the prescaler step.
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [DIV_W-1:0] freq_div,
    output logic [WIDTH-1:0] out,
    output logic             tick
);

    logic       step;
    logic [7:0] ph_reg, ph_next;
    logic [7:0] tri_reg, tri_next;
    dir_t       dir_reg, dir_next;
    logic [WIDTH-1:0] out_reg;
    logic       tick_reg;

    wave_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .freq_div (freq_div),
        .step     (step)
    );

    // Turning at 254/1 means each peak value is emitted for exactly one step.
    always_comb begin
        ph_next  = ph_reg + 8'd1;
        tri_next = tri_reg;
        dir_next = dir_reg;
        case (dir_reg)
            DIR_UP: begin
                tri_next = tri_reg + 8'd1;
                if (tri_reg == 8'd254) dir_next = DIR_DOWN;
            end
            DIR_DOWN: begin
                tri_next = tri_reg - 8'd1;
                if (tri_reg == 8'd1) dir_next = DIR_UP;
            end
            default: begin
                tri_next = '0;
                dir_next = DIR_UP;
            end
        endcase
    end

    // The mux sees next-state values so out carries the phase just entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_reg   <= '0;
            tri_reg  <= '0;
            dir_reg  <= DIR_UP;
            out_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= step;
            if (step) begin
                ph_reg  <= ph_next;
                tri_reg <= tri_next;
                dir_reg <= dir_next;
                out_reg <= wave_select(mode, ph_next, tri_next);
            end
        end
    end

    assign out  = out_reg;
    assign tick = tick_reg;

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: a behavioural model pushes expected samples
// into a scoreboard on each step; samples are popped and compared on tick.
module tb_wave_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [2:0]  mode;
    logic [15:0] freq_div;
    logic [7:0]  out;
    logic        tick;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb[$];

    logic [15:0] m_pcnt = '0;
    logic [7:0]  m_ph   = '0;
    logic [7:0]  m_tri  = '0;
    logic        m_down = 1'b0;
    logic        m_tick = 1'b0;
    logic        m_step;
    logic [7:0]  m_exp;

    wave_gen #(.DIV_W(16), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .mode     (mode),
        .freq_div (freq_div),
        .out      (out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model written from the waveform definitions.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pcnt = '0; m_ph = '0; m_tri = '0; m_down = 1'b0; m_tick = 1'b0;
            sb.delete();
        end else begin
            m_step = enable && (m_pcnt >= freq_div);
            m_tick = m_step;
            if (m_step) begin
                m_pcnt = '0;
                m_ph   = m_ph + 8'd1;
                if (!m_down) begin
                    m_tri = m_tri + 8'd1;
                    if (m_tri == 8'd255) m_down = 1'b1;
                end else begin
                    m_tri = m_tri - 8'd1;
                    if (m_tri == 8'd0) m_down = 1'b0;
                end
                case (mode)
                    3'b000:  m_exp = m_ph;
                    3'b001:  m_exp = ~m_ph;
                    3'b010:  m_exp = m_tri;
                    3'b011:  m_exp = m_ph[7] ? 8'hFF : 8'h00;
                    default: m_exp = 8'h80;
                endcase
                sb.push_back(m_exp);
            end else if (enable) begin
                m_pcnt = m_pcnt + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_val("tick", tick, m_tick);
            if (tick) begin
                if (sb.size() == 0) check_val("sb_empty", 1, 0);
                else check_val("out", out, sb.pop_front());
            end
        end
    end

    task automatic wait_tick(input int max_cycles, output int n);
        n = 0;
        while (n < max_cycles) begin
            @(negedge clk);
            n++;
            if (tick) break;
        end
        if (!tick) check_val("timeout", 0, 1);
    endtask

    int n;
    int peaks, zeros;
    logic [7:0] held;

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 3'b000; freq_div = 16'd3;
        repeat (3) @(negedge clk);
        check_val("rst_out", out, 0);
        check_val("rst_tick", tick, 0);

        // Sawtooth, sample period 4.
        rst = 1'b0; enable = 1'b1;
        wait_tick(20, n);
        check_val("saw_lat", n, 4);
        check_val("saw_first", out, 1);
        repeat (1100) @(negedge clk);
        $display("saw run done, out=%0h", out);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_val("arst_out", out, 0);
        check_val("arst_tick", tick, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(20, n);
        check_val("rst_relat", n, 4);
        check_val("rst_first", out, 1);

        // Triangle at full rate: one peak and one zero per 510 samples.
        mode = 3'b010; freq_div = 16'd0;
        peaks = 0; zeros = 0;
        for (int i = 0; i < 510; i++) begin
            @(negedge clk);
            if (out == 8'hFF) peaks++;
            if (out == 8'h00) zeros++;
        end
        check_val("tri_peaks", peaks, 1);
        check_val("tri_zeros", zeros, 1);
        repeat (600) @(negedge clk);
        $display("triangle run done, out=%0h", out);

        // Square, then reserved mode.
        mode = 3'b011;
        repeat (300) @(negedge clk);
        mode = 3'b100;
        @(negedge clk);
        check_val("mid", out, 8'h80);
        mode = 3'b001;
        repeat (40) @(negedge clk);

        // Lower freq_div below the running count.
        mode = 3'b000; freq_div = 16'd100;
        n = 0;
        while (m_pcnt != 16'd50 && n < 300) begin @(negedge clk); n++; end
        check_val("reach50", m_pcnt, 50);
        freq_div = 16'd10;
        @(negedge clk);
        check_val("fd_drop", tick, 1);
        wait_tick(30, n);
        check_val("fd_period", n, 11);
        $display("prescaler change done, out=%0h", out);

        // Freeze mid-count.
        n = 0;
        while (m_pcnt != 16'd5 && n < 30) begin @(negedge clk); n++; end
        enable = 1'b0;
        held = out;
        repeat (20) begin
            @(negedge clk);
            check_val("frz_out", out, held);
            check_val("frz_tick", tick, 0);
        end
        enable = 1'b1;
        wait_tick(30, n);
        check_val("resume_lat", n, 6);
        check_val("resume_out", out, held + 8'd1);
        repeat (50) @(negedge clk);

        enable = 1'b0;
        repeat (2) @(negedge clk);
        check_val("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
